// File: rtl/npu_sram_pkg.sv
// Shared definitions for the NPU scratch-SRAM port arbiter.
package npu_sram_pkg;

  localparam int NPU_AW = 12;
  localparam int NPU_DW = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

  // Converts a one-hot vector (up to 8 requesters) into its bit index.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/npu_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after start.
import npu_sram_pkg::*;

module npu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  win,
  output logic          found
);

  logic [N-1:0] elig;

  assign elig = req & ~excl;

  // Index start+k wrapped into 0..N-1 (start is always below N).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] s, input int k);
    int sum;
    sum = int'(s) + k;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // Scan N positions starting at start and take the first eligible one.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && elig[wrap_idx(start, k)]) begin
        win[wrap_idx(start, k)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NREQ single-beat masters,
// with lock-based bursts bounded by a hold limit when others are waiting.
import npu_sram_pkg::*;

module npu_sram_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = NPU_AW,
  parameter int DW       = NPU_DW,
  parameter int MAX_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*(DW/8)-1:0]  req_be,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DW-1:0]           rsp_data,
  output logic                    sram_chipselect,
  output logic                    sram_write,
  output logic [AW-1:0]           sram_address,
  output logic [(DW/8)-1:0]       sram_byteenable,
  output logic [DW-1:0]           sram_writedata,
  output logic                    sram_clken,
  input  logic [DW-1:0]           sram_readdata
);

  localparam int BEW = DW / 8;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e      state, state_d;
  logic [NREQ-1:0] grant, grant_d;
  logic [IW-1:0]   rr_ptr, rr_ptr_d;
  logic [HW-1:0]   hold_cnt, hold_cnt_d;
  logic [NREQ-1:0] rsp_valid_d;

  logic            g_valid, g_write, g_lock;
  logic [AW-1:0]   g_addr;
  logic [BEW-1:0]  g_be;
  logic [DW-1:0]   g_wdata;

  logic            fire, other_valid, hold_hit, rel_grant, load;
  logic [7:0]      grant_ext, win_ext;
  logic [IW-1:0]   pick_start;
  logic [NREQ-1:0] pick_excl, pick_win;
  logic            pick_found;

  // Position after index w, wrapped to 0..NREQ-1.
  function automatic logic [IW-1:0] next_idx(input logic [2:0] w);
    int n;
    n = int'(w) + 1;
    if (n >= NREQ) n = 0;
    return IW'(n);
  endfunction

  // Select the granted requester's beat fields (grant is one-hot or zero).
  always_comb begin
    g_valid = 1'b0;
    g_write = 1'b0;
    g_lock  = 1'b0;
    g_addr  = '0;
    g_be    = '0;
    g_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_valid = req_valid[i];
        g_write = req_write[i];
        g_lock  = req_lock[i];
        g_addr  = req_addr[i*AW +: AW];
        g_be    = req_be[i*BEW +: BEW];
        g_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign fire        = g_valid;
  assign other_valid = |(req_valid & ~grant);
  assign hold_hit    = (hold_cnt == HOLD_LAST) && other_valid;
  assign rel_grant   = (fire && !g_lock) || (!g_valid && !g_lock) || hold_hit;

  // Picker setup: from rr_ptr when idle, otherwise just after the current
  // owner, dropping the owner entirely when it is being forced off.
  always_comb begin
    grant_ext             = '0;
    grant_ext[NREQ-1:0]   = grant;
    pick_start            = rr_ptr;
    pick_excl             = '0;
    if (state == S_GRANT) begin
      pick_start = next_idx(onehot_to_idx(grant_ext));
      if (hold_hit) pick_excl = grant;
    end
  end

  npu_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .start (pick_start),
    .excl  (pick_excl),
    .win   (pick_win),
    .found (pick_found)
  );

  // Next-state logic: grant, round-robin pointer and hold counter.
  always_comb begin
    state_d           = state;
    grant_d           = grant;
    rr_ptr_d          = rr_ptr;
    hold_cnt_d        = hold_cnt;
    load              = 1'b0;
    win_ext           = '0;
    win_ext[NREQ-1:0] = pick_win;
    case (state)
      S_IDLE: begin
        if (|req_valid) load = pick_found;
      end
      S_GRANT: begin
        if (rel_grant) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_d = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    if (load) begin
      state_d    = S_GRANT;
      grant_d    = pick_win;
      rr_ptr_d   = next_idx(onehot_to_idx(win_ext));
      hold_cnt_d = '0;
    end
  end

  // A read beat flags its owner's response for exactly the following cycle.
  always_comb begin
    rsp_valid_d = '0;
    if (fire && !g_write) rsp_valid_d = grant;
  end

  // State registers, cleared asynchronously so in-flight responses are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      rsp_valid <= '0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      rr_ptr    <= rr_ptr_d;
      hold_cnt  <= hold_cnt_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  assign req_ready       = grant;
  assign sram_chipselect = fire;
  assign sram_write      = fire & g_write;
  assign sram_address    = g_addr;
  assign sram_byteenable = g_write ? g_be : {BEW{1'b1}};
  assign sram_writedata  = g_wdata;
  assign sram_clken      = 1'b1;
  assign rsp_data        = sram_readdata;

endmodule

// File: doc/npu_sram_arbiter.md
# npu_sram_arbiter

Round-robin arbiter that shares one port of a 4096×16 dual-port NPU scratch SRAM between up to NREQ on-chip masters, for example a weight loader, an activation fetcher and a result writer. Requesters issue single-word beats over a valid/ready handshake, and can hold the grant for a burst with a lock flag. Reads return one cycle after acceptance. The block sits between the NPU engines and the SRAM's s1/s2 Avalon-style port; one instance is used per SRAM port.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- AW, 12: word address width.
- DW, 16: data width; BEW = DW/8 byte enables.
- MAX_HOLD, 16: maximum consecutive granted cycles under lock while another requester is waiting.

Ports (vectors packed, requester i at slice i):
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  beat request.
- req_ready  out  NREQ  beat accepted when valid&ready.
- req_write  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep grant after this beat.
- req_addr  in  NREQ*AW  word address.
- req_be  in  NREQ*BEW  byte enables (writes only).
- req_wdata  in  NREQ*DW  write data.
- rsp_valid  out  NREQ  read data valid for requester i.
- rsp_data  out  DW  read data, shared by all requesters.
- sram_chipselect, sram_write  out  1  SRAM port controls.
- sram_address  out  AW; sram_byteenable  out  BEW; sram_writedata  out  DW.
- sram_clken  out  1  tied to 1.
- sram_readdata  in  DW  SRAM q (address registered, output unregistered).

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: one-hot `grant` register, exactly one bit set.
- req_ready[i] = grant[i] (combinational from the register). A beat fires when grant[g] & req_valid[g].
- The SRAM port is a combinational mux of the granted requester's signals:
  - sram_chipselect = fire.
  - sram_write = fire & req_write[g].
  - address, byteenable and writedata come from requester g.
  - Byteenable is forced to all-ones on reads.
- Release condition in GRANT, evaluated every cycle:
  - (fire & !req_lock[g]), or
  - (!req_valid[g] & !req_lock[g]), or
  - (hold_cnt == MAX_HOLD-1 & any other req_valid).
- On release, re-arbitrate at the same clock edge:
  - Round-robin search starts at g+1 mod NREQ, so g has the lowest priority.
  - On a hold-limit release, g is excluded from the search.
  - Winner found: load grant and stay in GRANT. No winner: go to IDLE.
- IDLE: if any req_valid, grant the round-robin winner starting at rr_ptr and enter GRANT. No beat fires in IDLE.
- rr_ptr updates to winner+1 whenever a grant is loaded.
- hold_cnt:
  - Clears when a grant is loaded.
  - Increments each cycle in GRANT.
  - Saturates at MAX_HOLD-1.
  - Counts stalled cycles under lock too.
- Read response: a read fire sets rsp_valid[g] for exactly the next cycle. rsp_data = sram_readdata, passed through combinationally.
- Back-to-back reads produce back-to-back rsp_valid.
- Writes produce no response.

## Timing
- Reset values (asynchronous): state IDLE, grant 0, rr_ptr 0, hold_cnt 0, rsp_valid 0.
  - Resulting outputs: req_ready 0, sram_chipselect 0, sram_write 0.
- Grant latency from IDLE: 1 cycle from req_valid to req_ready.
- Switching between requesters costs no bubble.
- Read latency: accept at cycle N, rsp_valid and data at N+1.
- A requester must hold valid, addr, write, be, wdata and lock stable until ready.
- If reset is asserted mid-burst, the in-flight rsp_valid is dropped. Requesters must discard outstanding reads on reset.
- If every requester asserts valid continuously with lock=0, each requester gets a grant at least once every NREQ cycles.

## Structure
- Package npu_sram_pkg holds:
  - the AW and DW defaults;
  - the state enum {S_IDLE, S_GRANT};
  - a function one-hot→index.
- Sub-module npu_rr_pick: purely combinational round-robin picker.
  - Inputs: request vector, start index, exclude mask.
  - Outputs: one-hot winner, found flag.
- Total RTL is roughly 200 lines.

## Test plan
- Reset with all req_valid high:
  - During reset: req_ready 0, chipselect 0.
  - First cycle after release: grant[0]=1. Then 1, 2, 3, 0 in successive cycles with lock=0.
- Write and readback:
  - Req1 writes 0xBEEF to addr 0x0A5 with be=2'b11, then reads 0x0A5.
  - Expected: rsp_valid[1] in the cycle after the read accept, rsp_data=0xBEEF, no rsp_valid on other bits.
- Byte-enable partial write:
  - Write 0x1234, then 0xAB00 with be=2'b10.
  - Read returns 0xAB34.
- Locked burst with hold limit:
  - Req0 has lock=1 and valid continuously; req2 has valid.
  - Req0 gets exactly 16 cycles, then grant moves to req2 on cycle 17 with no bubble.
- Lock stall:
  - Req3 has lock=1 and valid=0 for 5 cycles, with no other requester active.
  - Grant holds, no chipselect, hold_cnt=5.
- Mid-burst reset:
  - reset_n pulled low during req2's read burst.
  - Same cycle: grant and rsp_valid clear. Next request after reset is arbitrated from rr_ptr=0.
